featuremap_pad_writer: RTL
==========================

# featuremap_pad_writer

Producer side of the per-channel feature-map FIFOs that feed the conv2D featuremap stages. The block accepts a raster stream of one channel's WIDTH×HEIGHT activations and writes a zero-bordered (WIDTH+2)×(HEIGHT+2) frame into the channel FIFO. Writes are throttled by the FIFO almost-full flag, and the upstream stream is back-pressured while border words are inserted. One instance drives each channel FIFO; a 16-channel layer uses 16 instances.

## Interface
- DATA_WIDTH, 32, word width (IEEE-754 single).
- WIDTH, 56, unpadded row length.
- HEIGHT, 56, unpadded row count.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  DATA_WIDTH  upstream activation word.
- valid_in  in  1  data_in valid.
- ready_out  out  1  block can take data_in this cycle (combinational).
- data_fifo_almost_full  in  1  FIFO has ≤1 free entry.
- wrreq  out  1  FIFO write strobe (registered).
- data_out  out  DATA_WIDTH  FIFO write data (registered).
- frame_done  out  1  one-cycle pulse with the last write of a frame.

## Operation
- Padded frame positions (r,c): r in 0..HEIGHT+1, c in 0..WIDTH+1, raster order.
- Pad position: r==0, r==HEIGHT+1, c==0, or c==WIDTH+1. Pad word is 32'h0000_0000.
- All other positions are interior.
- Counters:
  - col counts 0..WIDTH+1 and wraps to 0.
  - row increments on col wrap.
  - Widths are $clog2(WIDTH+2) and $clog2(HEIGHT+2).
- FSM has two states:
  - IDLE: no writes, ready_out=0. Go to RUN when valid_in=1. The word is not consumed in IDLE.
  - RUN: step the positions. Go to IDLE in the cycle after the position (HEIGHT+1, WIDTH+1) advances.
- Define go = RUN && !data_fifo_almost_full.
- ready_out = go && interior.
- Accept = valid_in && ready_out.
- Advance = go && (pad || valid_in).
- On advance:
  - Next cycle: wrreq=1 and data_out = pad ? 0 : data_in.
  - col and row step.
- No advance: position holds; next-cycle wrreq=0 and data_out holds its value.
- Pad positions never consume input and never wait on valid_in.
- Interior positions wait for valid_in.
- almost_full stalls both pad and interior positions.
- Last position:
  - frame_done=1 in the same cycle as its wrreq.
  - Counters return to (0,0) and state returns to IDLE.
- Data is written bit-exact; no arithmetic.
- Written words per frame = (WIDTH+2)(HEIGHT+2), 3364 at defaults.
- Interior words consumed per frame = WIDTH·HEIGHT.

## Timing
- Reset values: wrreq=0, data_out=0, frame_done=0, ready_out=0, state=IDLE, row=col=0.
- Reset mid-frame:
  - Abandons the frame.
  - No write occurs in the cycle after reset.
  - The next frame starts at (0,0).
- Startup: valid_in high at cycle t in IDLE gives RUN at t+1. The first advance is at t+1 and the first wrreq at t+2.
- Latency from accept to wrreq is 1 cycle.
- Throughput is 1 word/cycle when there is no stall.
- almost_full stall:
  - almost_full sampled high at cycle t means no wrreq at t+1.
  - The flag has one entry of headroom, so the registered write issued the cycle before cannot overflow.
- almost_full and valid_in both high at an interior position: no accept and no advance; data_in must hold.
- Back-to-back frames:
  - Last advance at t; IDLE at t+1.
  - valid_in at t+1 gives RUN at t+2.
  - Exactly one bubble cycle of advance between frames.
- valid_in high during a pad position: ignored; the word is held by upstream.

## Test plan
- WIDTH=4, HEIGHT=3, valid_in always high, almost_full=0, inputs 1..12:
  - 30 consecutive wrreq.
  - Order: 6 zeros; then for each of the three rows: 0, four data words, 0; then 6 zeros.
  - Data rows are 1-4, 5-8, 9-12.
  - frame_done only on the 30th write.
  - ready_out high for exactly 12 cycles.
- Same setup, but almost_full high for 3 cycles mid-row 2:
  - Exactly 3 missing wrreq cycles.
  - Sequence identical to the first scenario.
  - No input word consumed while stalled.
- valid_in toggling 1/0 every cycle:
  - Pad writes continue regardless of valid_in.
  - Interior writes occur only on accepts.
  - Total 30 writes and 12 accepts.
- Two frames back-to-back:
  - Second frame's first wrreq exactly 2 cycles after the frame_done cycle.
  - Second frame's content correct.
- rst asserted mid-row 2, then a new frame:
  - Outputs 0 in the cycle after rst.
  - The new frame starts with 6 zero writes from (0,0).
  - frame_done fires once, only for the new frame.
- Defaults (56×56), random almost_full at 20% duty:
  - Exactly 3364 writes.
  - Scoreboard matches the padded reference frame.

Source files
------------

// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer: writes one channel's WIDTH x HEIGHT raster stream into its
// FIFO as a zero-bordered (WIDTH+2) x (HEIGHT+2) frame. Latency: accept -> wrreq 1 cycle.
// Backpressure: FIFO almost-full stalls every position; upstream is held off on pad words.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   data_in, valid_in        upstream activation stream
//   ready_out                combinational; high only at an interior position that can write
//   data_fifo_almost_full    FIFO has at most one free entry
//   wrreq, data_out          registered FIFO write strobe and data
//   frame_done               pulses together with the last write of a frame
module featuremap_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  data_fifo_almost_full,
  output logic                  wrreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic pad;
  logic go;
  logic advance;
  logic last_pos;

  assign pad      = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);
  // almost_full leaves one entry of headroom, so the write registered in the
  // previous cycle still fits even though this cycle's flag is already high.
  assign go       = (state == RUN) && !data_fifo_almost_full;
  assign ready_out = go && !pad;
  // Pad words are generated locally and never wait on the upstream stream.
  assign advance  = go && (pad || valid_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      wrreq      <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      wrreq      <= advance;
      frame_done <= advance && last_pos;
      if (advance) begin
        data_out <= pad ? '0 : data_in;
      end

      case (state)
        IDLE: begin
          // The word that wakes us is not consumed here; it is taken at the
          // first interior position once RUN has written the top border.
          if (valid_in) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            if (last_pos) begin
              col   <= '0;
              row   <= '0;
              state <= IDLE;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
